instr_prefetch: RTL

//  Parametrised instruction fetch unit with a prefetch queue; successor to instr_fetch.

---
 rtl/instr_prefetch_pkg.sv | 15 +
 rtl/instr_prefetch_fetch_fifo.sv | 69 ++++++
 rtl/instr_prefetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit.
//   PF_WORD_SIZE / PF_ADDR_SIZE : default instruction word and word-address widths
//   pf_state_t                  : fetch FSM state encoding
package instr_prefetch_pkg;

    localparam int PF_WORD_SIZE = 16;
    localparam int PF_ADDR_SIZE = 16;

    typedef enum logic [1:0] {
        PF_IDLE    = 2'd0,
        PF_WAIT    = 2'd1,
        PF_DISCARD = 2'd2
    } pf_state_t;

endpackage

// File: rtl/instr_prefetch_fetch_fifo.sv
// fetch_fifo: DEPTH-entry register FIFO holding {instruction, pc} pairs.
// The head entry is read straight from the storage registers.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous clear; wins over push/pop
//   push, push_data write one entry
//   pop             advance the head (ignored when empty)
//   head_data       current head entry
//   count           number of valid entries (0..DEPTH)
//   empty           count == 0
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign pop_ok = pop && !empty;
    // A push into a full queue is accepted only when the head leaves on the same edge.
    assign push_ok = push && (!full || pop_ok);

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: instruction fetch unit with a DEPTH-entry prefetch queue.
// Streams sequential words from the fetch pc into the queue and hands them to
// decode over a valid/ready handshake. A redirect flushes the queue and drops
// any memory response still in flight.
// Optional feature macro: PREFETCH_STATS_EN adds fetch_count / flush_count.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   mem_req, mem_addr   memory read request, held until mem_ack
//   mem_ack, mem_rdata  memory response
//   instr_valid, instr, instr_pc, instr_ready   queue head to decode
//   redirect, redirect_pc                       flush and restart fetch
//   fetch_count, flush_count                    (PREFETCH_STATS_EN only)
//
// state      | meaning
// PF_IDLE    | no request outstanding; issue when the queue has room
// PF_WAIT    | request outstanding, response will be enqueued
// PF_DISCARD | request outstanding after a redirect, response will be dropped
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int          WORD_SIZE = PF_WORD_SIZE,
    parameter int          ADDR_SIZE = PF_ADDR_SIZE,
    parameter int          DEPTH     = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr,
    output logic [ADDR_SIZE-1:0] instr_pc,
    input  logic                 instr_ready,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_pc
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]          fetch_count,
    output logic [15:0]          flush_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = WORD_SIZE + ADDR_SIZE;

    pf_state_t            state, state_nxt;
    logic [ADDR_SIZE-1:0] pc, pc_nxt;
    logic [ADDR_SIZE-1:0] target, target_nxt;
    logic                 mem_req_nxt;
    logic [ADDR_SIZE-1:0] mem_addr_nxt;

    logic [CW-1:0]        count;
    logic [CW-1:0]        count_after;
    logic                 fifo_empty;
    logic [FW-1:0]        head_data;
    logic                 enq;
    logic                 deq;

    assign instr_valid = !fifo_empty;
    assign instr       = head_data[FW-1 -: WORD_SIZE];
    assign instr_pc    = head_data[ADDR_SIZE-1:0];

    // Redirect drops both a concurrent dequeue and a concurrent response.
    assign deq = instr_valid && instr_ready && !redirect;
    assign enq = (state == PF_WAIT) && mem_ack && !redirect;

    assign count_after = count + CW'(enq) - CW'(deq);

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .flush     (redirect),
        .push      (enq),
        .push_data ({mem_rdata, mem_addr}),
        .pop       (deq),
        .head_data (head_data),
        .count     (count),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        target_nxt   = target;
        mem_req_nxt  = mem_req;
        mem_addr_nxt = mem_addr;

        if (redirect) begin
            if (state == PF_IDLE || mem_ack) begin
                // Nothing left in flight after this edge: restart immediately.
                state_nxt    = PF_WAIT;
                mem_req_nxt  = 1'b1;
                mem_addr_nxt = redirect_pc;
                pc_nxt       = redirect_pc;
            end else begin
                // Old request must complete on its original address first.
                state_nxt  = PF_DISCARD;
                target_nxt = redirect_pc;
            end
        end else begin
            case (state)
                PF_IDLE: begin
                    if (count < CW'(DEPTH)) begin
                        state_nxt    = PF_WAIT;
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = pc;
                    end
                end
                PF_WAIT: begin
                    if (mem_ack) begin
                        pc_nxt = pc + ADDR_SIZE'(1);
                        if (count_after < CW'(DEPTH)) begin
                            mem_addr_nxt = pc + ADDR_SIZE'(1);
                        end else begin
                            mem_req_nxt = 1'b0;
                            state_nxt   = PF_IDLE;
                        end
                    end
                end
                PF_DISCARD: begin
                    if (mem_ack) begin
                        pc_nxt      = target;
                        mem_req_nxt = 1'b0;
                        state_nxt   = PF_IDLE;
                    end
                end
                default: begin
                    state_nxt   = PF_IDLE;
                    mem_req_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= PF_IDLE;
            pc       <= ADDR_SIZE'(RESET_PC);
            target   <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            target   <= target_nxt;
            mem_req  <= mem_req_nxt;
            mem_addr <= mem_addr_nxt;
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (enq) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
